// File: rtl/mem_pkg.sv
// Shared types for the memory stage: FSM state encoding and the writeback bundle.
package mem_pkg;

  localparam int unsigned MemDataW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic [2:0]          dest;
    logic [MemDataW-1:0] data;
    logic                misalign;
    logic                buserr;
  } wb_bundle_t;

  // Halfword accesses need an even byte address.
  function automatic logic is_misaligned(input logic [MemDataW-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side, data-memory and writeback signals of the memory stage.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic              ex_valid_p3;
  logic              ex_ready_p3;
  logic [DATA_W-1:0] alu_output_data_p3;
  logic [DATA_W-1:0] st_data_p3;
  logic              ld_p3;
  logic              st_p3;
  logic              link_p3;
  logic [DATA_W-1:0] nxt_pc_p3;
  logic [2:0]        dest_reg_p3;
  logic              reg_write_valid_p3;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  logic              wb_valid_p4;
  logic              wb_reg_write_p4;
  logic [2:0]        wb_dest_reg_p4;
  logic [DATA_W-1:0] wb_data_p4;
  logic              exc_misalign_p4;
  logic              exc_buserr_p4;

  // Environment view: drives execute results and memory responses.
  modport master (
    output ex_valid_p3, alu_output_data_p3, st_data_p3, ld_p3, st_p3, link_p3, nxt_pc_p3,
           dest_reg_p3, reg_write_valid_p3, dmem_ack, dmem_rdata,
    input  ex_ready_p3, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid_p4,
           wb_reg_write_p4, wb_dest_reg_p4, wb_data_p4, exc_misalign_p4, exc_buserr_p4
  );

  // Memory stage view.
  modport slave (
    input  ex_valid_p3, alu_output_data_p3, st_data_p3, ld_p3, st_p3, link_p3, nxt_pc_p3,
           dest_reg_p3, reg_write_valid_p3, dmem_ack, dmem_rdata,
    output ex_ready_p3, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid_p4,
           wb_reg_write_p4, wb_dest_reg_p4, wb_data_p4, exc_misalign_p4, exc_buserr_p4
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Clear/enable cycle counter that saturates at TIMEOUT_CYCLES-1 and flags the limit.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic at_limit_o
);

  logic [15:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-stage controller: passes ALU results through, runs LD/ST as req/ack transactions,
// and emits a registered writeback bundle with misalign/bus-error flags.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DATA_W         = MemDataW
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  mem_state_t        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic              we_q, we_d, ld_q, ld_d, rw_q, rw_d, err_q, err_d;
  logic [2:0]        dest_q, dest_d;
  wb_bundle_t        wb_q, wb_d;

  logic accept, is_mem, misaligned, at_limit;

  assign accept     = bus.ex_valid_p3 && (state_q == IDLE);
  assign is_mem     = bus.ld_p3 || bus.st_p3;
  assign misaligned = is_misaligned(bus.alu_output_data_p3);

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q != ACCESS),
    .en_i       ((state_q == ACCESS) && !bus.dmem_ack),
    .at_limit_o (at_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && is_mem && !misaligned) state_d = ACCESS;
      ACCESS:  if (bus.dmem_ack || at_limit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    ld_d    = ld_q;
    rw_d    = rw_q;
    err_d   = err_q;
    dest_d  = dest_q;
    wb_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_d.valid     = 1'b1;
            wb_d.reg_write = bus.reg_write_valid_p3;
            wb_d.dest      = bus.dest_reg_p3;
            wb_d.data      = bus.link_p3 ? bus.nxt_pc_p3 : bus.alu_output_data_p3;
          end else if (misaligned) begin
            wb_d.valid    = 1'b1;
            wb_d.misalign = 1'b1;
            wb_d.dest     = bus.dest_reg_p3;
            wb_d.data     = bus.alu_output_data_p3;
          end else begin
            addr_d  = {bus.alu_output_data_p3[DATA_W-1:1], 1'b0};
            wdata_d = bus.st_data_p3;
            we_d    = bus.st_p3;
            ld_d    = bus.ld_p3;
            rw_d    = bus.reg_write_valid_p3;
            dest_d  = bus.dest_reg_p3;
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        // An ack in the limit cycle takes priority over the timeout.
        if (bus.dmem_ack) begin
          rdata_d = bus.dmem_rdata;
        end else if (at_limit) begin
          err_d = 1'b1;
        end
      end
      RESP: begin
        wb_d.valid     = 1'b1;
        wb_d.dest      = dest_q;
        wb_d.buserr    = err_q;
        wb_d.reg_write = ld_q && rw_q && !err_q;
        wb_d.data      = ld_q ? rdata_q : addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      dest_q  <= '0;
      wb_q    <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      dest_q  <= dest_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.ex_ready_p3     = (state_q == IDLE);
  assign bus.dmem_req        = (state_q == ACCESS);
  assign bus.dmem_we         = we_q && (state_q == ACCESS);
  assign bus.dmem_addr       = addr_q;
  assign bus.dmem_wdata      = wdata_q;
  assign bus.wb_valid_p4     = wb_q.valid;
  assign bus.wb_reg_write_p4 = wb_q.reg_write;
  assign bus.wb_dest_reg_p4  = wb_q.dest;
  assign bus.wb_data_p4      = wb_q.data;
  assign bus.exc_misalign_p4 = wb_q.misalign;
  assign bus.exc_buserr_p4   = wb_q.buserr;

endmodule
